mont_enc: RTL and testbench

Montgomery-domain encoder: computes Z = A·2^(R·NW) mod q for the Montgomery-friendly modulus q = qH·2^R + 1. It is the inverse direction of the word-level Montgomery reduction, which divides by 2^R per stage. The block lifts operands into the Montgomery domain before they enter the reduction datapath. It is sequential and bit-serial, with one modular doubling per cycle and valid/ready handshakes on both sides.

---
 rtl/mont_enc_pkg.sv | 22 ++
 rtl/mont_enc_if.sv | 27 ++
 rtl/mod_csub.sv | 16 +
 rtl/mont_enc.sv | 83 ++++++++
 tb/tb_mont_enc.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mont_enc_pkg.sv
// Shared definitions for the Montgomery-domain encoder: FSM encoding and
// latency / counter-width helpers used by the RTL and its users.
package mont_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Cycles from input handshake to first out_valid.
    function automatic int mont_enc_lat(input int r, input int nw);
        return r * nw + 2;
    endfunction

    // Counter must be able to hold N = r*nw.
    function automatic int mont_enc_cnt_w(input int r, input int nw);
        return $clog2(r * nw + 1);
    endfunction

endpackage

// File: rtl/mont_enc_if.sv
// Operand/result handshake bundle for mont_enc; master drives operands and
// consumes results, slave is the encoder.
interface mont_enc_if #(
    parameter int LOGQH = 26,
    parameter int R     = 34
);
    localparam int LOGQ = LOGQH + R;

    logic [LOGQH-1:0] qH;
    logic [LOGQ-1:0]  A;
    logic             in_valid;
    logic             in_ready;
    logic [LOGQ-1:0]  Z;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output qH, A, in_valid, out_ready,
        input  in_ready, Z, out_valid
    );

    modport slave (
        input  qH, A, in_valid, out_ready,
        output in_ready, Z, out_valid
    );

endinterface

// File: rtl/mod_csub.sv
// Conditional subtract: out = (x >= q) ? x - q : x, decided by the borrow of
// a one-bit-wider subtraction.
module mod_csub #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] q,
    output logic [W-1:0] out
);

    logic [W:0] d;

    assign d   = {1'b0, x} - {1'b0, q};
    assign out = d[W] ? x : d[W-1:0];

endmodule

// File: rtl/mont_enc.sv
// Bit-serial Montgomery lift: Z = A * 2^(R*NW) mod q, q = qH*2^R + 1, using
// one modular doubling per cycle after an initial reduction of A below q.
module mont_enc
    import mont_enc_pkg::*;
#(
    parameter int LOGQH = 26,
    parameter int R     = 34,
    parameter int NW    = 1
) (
    input logic      clk,
    input logic      rst,
    mont_enc_if.slave io
);

    localparam int LOGQ = LOGQH + R;
    localparam int N    = R * NW;
    localparam int CW   = mont_enc_cnt_w(R, NW);

    state_t          state_reg;
    logic [LOGQ-1:0] z_reg;
    logic [LOGQ-1:0] q_reg;
    logic [CW-1:0]   cnt_reg;

    logic [LOGQ:0]   csub_x;
    logic [LOGQ:0]   csub_out;
    logic            unused_csub_msb;

    // PRE reduces z itself; RUN reduces 2z. In both cases the result is < q,
    // so the top bit of the subtractor output is always zero.
    assign csub_x = (state_reg == ST_RUN) ? {z_reg, 1'b0} : {1'b0, z_reg};

    mod_csub #(
        .W(LOGQ + 1)
    ) u_csub (
        .x  (csub_x),
        .q  ({1'b0, q_reg}),
        .out(csub_out)
    );

    assign unused_csub_msb = csub_out[LOGQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            z_reg     <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (io.in_valid) begin
                        z_reg     <= io.A;
                        q_reg     <= {io.qH, {R{1'b0}}} + LOGQ'(1);
                        state_reg <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    z_reg     <= csub_out[LOGQ-1:0];
                    cnt_reg   <= '0;
                    state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    z_reg   <= csub_out[LOGQ-1:0];
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(N - 1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (io.out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state_reg == ST_IDLE);
    assign io.out_valid = (state_reg == ST_DONE);
    assign io.Z         = z_reg;

endmodule

// File: tb/tb_mont_enc.sv
// Bench for mont_enc: directed small-modulus cases, back-pressure and reset,
// then random operands on the default configuration against a wide-integer model.
module tb_mont_enc;

    typedef logic [127:0] w128_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mont_enc_if #(.LOGQH(26), .R(34)) if0 ();
    mont_enc_if #(.LOGQH(4),  .R(4))  if1 ();
    mont_enc_if #(.LOGQH(4),  .R(4))  if2 ();

    mont_enc #(.LOGQH(26), .R(34), .NW(1)) d0 (.clk(clk), .rst(rst), .io(if0));
    mont_enc #(.LOGQH(4),  .R(4),  .NW(1)) d1 (.clk(clk), .rst(rst), .io(if1));
    mont_enc #(.LOGQH(4),  .R(4),  .NW(2)) d2 (.clk(clk), .rst(rst), .io(if2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input w128_t got, input w128_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input w128_t a, input w128_t qh, input logic v);
        case (which)
            0: begin if0.A = a[59:0]; if0.qH = qh[25:0]; if0.in_valid = v; end
            1: begin if1.A = a[7:0];  if1.qH = qh[3:0];  if1.in_valid = v; end
            default: begin if2.A = a[7:0]; if2.qH = qh[3:0]; if2.in_valid = v; end
        endcase
    endtask

    task automatic set_oready(input int which, input logic r);
        case (which)
            0: if0.out_ready = r;
            1: if1.out_ready = r;
            default: if2.out_ready = r;
        endcase
    endtask

    function automatic logic get_ov(input int which);
        case (which)
            0: return if0.out_valid;
            1: return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int which);
        case (which)
            0: return if0.in_ready;
            1: return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic w128_t get_z(input int which);
        case (which)
            0: return w128_t'(if0.Z);
            1: return w128_t'(if1.Z);
            default: return w128_t'(if2.Z);
        endcase
    endfunction

    // Called just after an edge with the DUT idle; lat counts edges from the
    // input handshake to the first cycle with out_valid high.
    task automatic run_op(input int which, input w128_t a, input w128_t qh,
                          input int hold, output w128_t z, output int lat);
        drive(which, a, qh, 1'b1);
        @(posedge clk); #1;
        drive(which, '0, '0, 1'b0);
        lat = 1;
        while (!get_ov(which) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        z = get_z(which);
        repeat (hold) begin @(posedge clk); #1; end
        set_oready(which, 1'b1);
        @(posedge clk); #1;
        set_oready(which, 1'b0);
    endtask

    // Reference: lift by plain wide modular arithmetic.
    function automatic w128_t ref_lift(input w128_t a, input w128_t qh, input int r, input int nw);
        w128_t q;
        q = (qh << r) + 128'd1;
        return (a << (r * nw)) % q;
    endfunction

    // One word of Montgomery reduction for q = 1 mod 2^r: (z + m*q) / 2^r.
    function automatic w128_t mont_reduce(input w128_t z, input w128_t q, input int r);
        w128_t mask, m;
        mask = (128'd1 << r) - 128'd1;
        m    = ((128'd1 << r) - (z & mask)) & mask;
        return (z + m * q) >> r;
    endfunction

    initial begin
        w128_t z, a, qh, q, exp_z;
        int    lat;

        drive(0, '0, '0, 1'b0);
        drive(1, '0, '0, 1'b0);
        drive(2, '0, '0, 1'b0);
        set_oready(0, 1'b0);
        set_oready(1, 1'b0);
        set_oready(2, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_z1",  get_z(1), 128'd0);
        chk("rst_ov1", w128_t'(get_ov(1)), 128'd0);
        chk("rst_ir1", w128_t'(get_ir(1)), 128'd1);
        chk("rst_z0",  get_z(0), 128'd0);
        chk("rst_ov0", w128_t'(get_ov(0)), 128'd0);
        chk("rst_ir0", w128_t'(get_ir(0)), 128'd1);
        @(posedge clk); #1;

        // q = 145 directed cases
        run_op(1, 128'd1, 128'd9, 0, z, lat);
        $display("small A=1 Z=%0d lat=%0d", z, lat);
        chk("a1_z", z, 128'd16);
        chk("a1_lat", w128_t'(lat), 128'd6);

        run_op(1, 128'd100, 128'd9, 0, z, lat);
        $display("small A=100 Z=%0d lat=%0d", z, lat);
        chk("a100_z", z, 128'd5);

        run_op(1, 128'd200, 128'd9, 0, z, lat);
        $display("small A=200 Z=%0d lat=%0d", z, lat);
        chk("a200_z", z, 128'd10);
        chk("a200_lat", w128_t'(lat), 128'd6);

        run_op(2, 128'd1, 128'd9, 0, z, lat);
        $display("nw2 A=1 Z=%0d lat=%0d", z, lat);
        chk("nw2_z", z, 128'd111);
        chk("nw2_lat", w128_t'(lat), 128'd10);

        // Back-pressure with in_valid held high (different A) throughout
        drive(1, 128'd100, 128'd9, 1'b1);
        @(posedge clk); #1;
        drive(1, 128'd7, 128'd9, 1'b1);
        lat = 1;
        while (!get_ov(1) && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("bp_lat", w128_t'(lat), 128'd6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_z",  get_z(1), 128'd5);
            chk("bp_ov", w128_t'(get_ov(1)), 128'd1);
            chk("bp_ir", w128_t'(get_ir(1)), 128'd0);
        end
        drive(1, '0, '0, 1'b0);
        set_oready(1, 1'b1);
        @(posedge clk); #1;
        set_oready(1, 1'b0);
        $display("backpressure Z=5 held 5 cycles, released");
        chk("bp_ir_after", w128_t'(get_ir(1)), 128'd1);
        chk("bp_ov_after", w128_t'(get_ov(1)), 128'd0);

        // Reset during the second RUN cycle
        drive(1, 128'd200, 128'd9, 1'b1);
        @(posedge clk); #1;
        drive(1, '0, '0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset in RUN");
        chk("mid_rst_ov", w128_t'(get_ov(1)), 128'd0);
        chk("mid_rst_ir", w128_t'(get_ir(1)), 128'd1);
        chk("mid_rst_z",  get_z(1), 128'd0);
        run_op(1, 128'd1, 128'd9, 0, z, lat);
        $display("after reset A=1 Z=%0d lat=%0d", z, lat);
        chk("post_rst_z", z, 128'd16);

        // Random operands on the default configuration
        for (int i = 0; i < 1000; i++) begin
            if (i == 0) begin
                a  = (128'd1 << 60) - 128'd1;
                qh = 128'h2000000;
            end else if (i == 1) begin
                a  = 128'd0;
                qh = 128'h3FFFFFF;
            end else begin
                a  = {64'd0, 32'($urandom), 32'($urandom)} & ((128'd1 << 60) - 128'd1);
                qh = (w128_t'($urandom) & 128'h3FFFFFF) | 128'h2000000;
            end
            q     = (qh << 34) + 128'd1;
            exp_z = ref_lift(a, qh, 34, 1);
            run_op(0, a, qh, int'($urandom_range(0, 3)), z, lat);
            $display("rand %0d A=%0h qH=%0h Z=%0h exp=%0h lat=%0d", i, a, qh, z, exp_z, lat);
            chk("rand_z", z, exp_z);
            chk("rand_lat", w128_t'(lat), 128'd36);
            chk("rand_reduce", mont_reduce(z, q, 34) % q, a % q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
